// File: rtl/cache_data_bank_if.sv
// ============================================================================
// Module      : cache_data_bank_if
// Description : Bus bundle for the multi-way L1 data bank.
//               master = cache control side, slave = data bank.
//               Groups: registered read port (rd_*), store-hit port (wr_*),
//               refill sequencer port (rf_*, beat_*).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_data_bank_if #(
    parameter int WAYS   = 4,
    parameter int SET_AW = 6,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int WAY_AW = 2,
    parameter int OFF_AW = 3
);
    // read port
    logic                   rd_en;
    logic [SET_AW-1:0]      rd_set;
    logic                   rd_valid;
    logic [WAYS*LINE_W-1:0] rd_data;
    // store-hit port
    logic                   wr_en;
    logic                   wr_ready;
    logic [WAY_AW-1:0]      wr_way;
    logic [SET_AW-1:0]      wr_set;
    logic [OFF_AW-1:0]      wr_off;
    logic [BEAT_W/8-1:0]    wr_strb;
    logic [BEAT_W-1:0]      wr_data;
    // refill port
    logic                   rf_start;
    logic [WAY_AW-1:0]      rf_way;
    logic [SET_AW-1:0]      rf_set;
    logic                   beat_valid;
    logic                   beat_ready;
    logic [BEAT_W-1:0]      beat_data;
    logic                   beat_last;
    logic                   rf_busy;
    logic                   rf_done;

    modport master (
        output rd_en, rd_set,
        input  rd_valid, rd_data,
        output wr_en, wr_way, wr_set, wr_off, wr_strb, wr_data,
        input  wr_ready,
        output rf_start, rf_way, rf_set, beat_valid, beat_data, beat_last,
        input  beat_ready, rf_busy, rf_done
    );

    modport slave (
        input  rd_en, rd_set,
        output rd_valid, rd_data,
        input  wr_en, wr_way, wr_set, wr_off, wr_strb, wr_data,
        output wr_ready,
        input  rf_start, rf_way, rf_set, beat_valid, beat_data, beat_last,
        output beat_ready, rf_busy, rf_done
    );
endinterface

`default_nettype wire

// File: rtl/cache_data_bank.sv
// ============================================================================
// Module      : cache_data_bank
// Description : WAYS x SETS L1 data storage with a registered all-ways read
//               port, a byte-masked single-beat store path and a refill
//               sequencer that assembles a beat burst into one line and
//               commits it to the chosen way.
// Ports       : clk, resetn (synchronous, active low),
//               bus (cache_data_bank_if.slave): rd_*, wr_*, rf_*, beat_*
// Option      : DBANK_BYPASS_EN - when defined, a read of a set written in
//               the same cycle returns the post-write line (write-first);
//               otherwise the read returns the pre-write line (read-first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_data_bank #(
    parameter int WAYS   = 4,
    parameter int SET_AW = 6,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32,
    parameter int WAY_AW = 2,
    parameter int OFF_AW = 3
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    cache_data_bank_if.slave  bus
);
    localparam int SETS       = 2**SET_AW;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int STRB_W     = BEAT_W / 8;
    localparam int LINE_BYTES = LINE_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [OFF_AW-1:0] cnt;
    logic [LINE_W-1:0] line_buf;
    logic [WAY_AW-1:0] fill_way;
    logic [SET_AW-1:0] fill_set;
    logic              beat_fire;
    logic              commit_we;
    logic              store_we;
    logic [LINE_W-1:0] store_old [WAYS];
    logic [LINE_W-1:0] store_line;

    // ---------------- refill FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (bus.rf_start) state_next = ST_FILL;
            ST_FILL:   if (beat_fire && (bus.beat_last || cnt == OFF_AW'(BEATS-1)))
                           state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.beat_ready = (state == ST_FILL);
        bus.rf_busy    = (state != ST_IDLE);
        bus.rf_done    = (state == ST_COMMIT);
        bus.wr_ready   = (state != ST_COMMIT);
    end

    assign beat_fire = bus.beat_valid && bus.beat_ready;
    // A reset landing on the COMMIT cycle must not write the line.
    assign commit_we = (state == ST_COMMIT) && resetn;
    assign store_we  = bus.wr_en && bus.wr_ready;

    // Line buffer and beat counter. The counter saturates on the last slot:
    // the FSM always leaves FILL on that beat, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == ST_IDLE && bus.rf_start) begin
            cnt      <= '0;
            line_buf <= '0;
            fill_way <= bus.rf_way;
            fill_set <= bus.rf_set;
        end else if (beat_fire) begin
            line_buf[int'(cnt)*BEAT_W +: BEAT_W] <= bus.beat_data;
            if (cnt != OFF_AW'(BEATS-1)) cnt <= cnt + 1'b1;
        end
    end

    // Store path: merge the enabled bytes of the addressed beat into the
    // current line; the merged line is also the write-first forward value.
    always_comb begin
        store_line = store_old[bus.wr_way];
        for (int b = 0; b < LINE_BYTES; b++) begin
            if ((b / STRB_W) == int'(bus.wr_off) && bus.wr_strb[b % STRB_W])
                store_line[b*8 +: 8] = bus.wr_data[(b % STRB_W)*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) bus.rd_valid <= 1'b0;
        else         bus.rd_valid <= bus.rd_en;
    end

    // ---------------- per-way storage and read register ----------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [LINE_W-1:0] mem [SETS];
        logic [LINE_W-1:0] rd_next;
        logic [LINE_W-1:0] rd_line;

        assign store_old[w] = mem[bus.wr_set];

        // COMMIT and an accepted store are mutually exclusive (wr_ready=0).
        always_ff @(posedge clk) begin
            if (commit_we && fill_way == WAY_AW'(w))
                mem[fill_set] <= line_buf;
            else if (store_we && bus.wr_way == WAY_AW'(w))
                mem[bus.wr_set] <= store_line;
        end

        always_comb begin
`ifdef DBANK_BYPASS_EN
            if (commit_we && fill_way == WAY_AW'(w) && fill_set == bus.rd_set)
                rd_next = line_buf;
            else if (store_we && bus.wr_way == WAY_AW'(w) && bus.wr_set == bus.rd_set)
                rd_next = store_line;
            else
                rd_next = mem[bus.rd_set];
`else
            rd_next = mem[bus.rd_set];
`endif
        end

        always_ff @(posedge clk) begin
            if (!resetn)        rd_line <= '0;
            else if (bus.rd_en) rd_line <= rd_next;
        end

        assign bus.rd_data[w*LINE_W +: LINE_W] = rd_line;
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_data_bank.sv
// ============================================================================
// Module      : tb_cache_data_bank
// Description : Self-checking bench for cache_data_bank. A transaction-level
//               model (line array + beat queue) predicts every output each
//               cycle; literal line values pin the model at key points.
//               Honours DBANK_BYPASS_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_data_bank;
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_data_bank_if bus();

    cache_data_bank dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [255:0] mdl [4][64];
    bit           mk  [4][64];
    logic [255:0] e_rd [4];
    bit           e_k  [4];
    bit           e_rv;
    int           ph;          // 0 idle, 1 collecting beats, 2 line being written
    logic [31:0]  bq [$];
    int           f_way, f_set;
    bit           m_on = 0;
    logic [255:0] cl, sl;

    task automatic sample_reads();
        for (int w = 0; w < 4; w++) begin
            e_rd[w] = mdl[w][bus.rd_set];
            e_k[w]  = mk[w][bus.rd_set];
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            m_on = 1;
            e_rv = 0;
            for (int w = 0; w < 4; w++) begin e_rd[w] = '0; e_k[w] = 1; end
            ph = 0;
            bq.delete();
        end else begin
`ifndef DBANK_BYPASS_EN
            if (bus.rd_en) sample_reads();
`endif
            if (ph == 2) begin
                cl = '0;
                foreach (bq[i]) cl[i*32 +: 32] = bq[i];
                mdl[f_way][f_set] = cl;
                mk[f_way][f_set]  = 1;
            end else if (bus.wr_en) begin
                sl = mdl[bus.wr_way][bus.wr_set];
                for (int i = 0; i < 4; i++)
                    if (bus.wr_strb[i]) sl[int'(bus.wr_off)*32 + i*8 +: 8] = bus.wr_data[i*8 +: 8];
                mdl[bus.wr_way][bus.wr_set] = sl;
            end
`ifdef DBANK_BYPASS_EN
            if (bus.rd_en) sample_reads();
`endif
            e_rv = bus.rd_en;
            case (ph)
                0: if (bus.rf_start) begin
                       ph = 1; f_way = bus.rf_way; f_set = bus.rf_set; bq.delete();
                   end
                1: if (bus.beat_valid) begin
                       bq.push_back(bus.beat_data);
                       if (bus.beat_last || bq.size() == 8) ph = 2;
                   end
                default: ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("rd_valid",   256'(bus.rd_valid),   256'(e_rv));
            chk("beat_ready", 256'(bus.beat_ready), 256'(ph == 1));
            chk("rf_busy",    256'(bus.rf_busy),    256'(ph != 0));
            chk("rf_done",    256'(bus.rf_done),    256'(ph == 2));
            chk("wr_ready",   256'(bus.wr_ready),   256'(ph != 2));
            for (int w = 0; w < 4; w++)
                if (e_k[w]) chk($sformatf("rd_data_w%0d", w), bus.rd_data[w*256 +: 256], e_rd[w]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] s);
        bus.rd_en = 1'b1; bus.rd_set = s;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_store(input logic [1:0] w, input logic [5:0] s, input logic [2:0] o,
                            input logic [3:0] st, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_way = w; bus.wr_set = s; bus.wr_off = o;
        bus.wr_strb = st; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // Ends right after the edge that accepted the final driven beat.
    task automatic refill(input logic [1:0] w, input logic [5:0] s, input int nbeats,
                          input int last_at, input int rst_at, input int glitch_at,
                          input logic [31:0] base, input logic [31:0] step);
        bus.rf_start = 1'b1; bus.rf_way = w; bus.rf_set = s;
        tick();
        bus.rf_start = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.beat_valid = 1'b1;
            bus.beat_data  = base + step * 32'(i);
            bus.beat_last  = (i + 1 == last_at);
            resetn         = !(i + 1 == rst_at);
            if (i + 1 == glitch_at) begin
                bus.rf_start = 1'b1; bus.rf_way = w ^ 2'd1; bus.rf_set = s ^ 6'd1;
            end
            tick();
            bus.rf_start = 1'b0;
            resetn       = 1'b1;
        end
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
    endtask

    localparam logic [255:0] LINE_A =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [255:0] LINE_B =
        256'h88888888_77777777_66666666_55555555_44BB44DD_33333333_22222222_11111111;

    initial begin
        bus.rd_en = 0; bus.rd_set = 0;
        bus.wr_en = 0; bus.wr_way = 0; bus.wr_set = 0; bus.wr_off = 0;
        bus.wr_strb = 0; bus.wr_data = 0;
        bus.rf_start = 0; bus.rf_way = 0; bus.rf_set = 0;
        bus.beat_valid = 0; bus.beat_data = 0; bus.beat_last = 0;
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        // read latency and reset during a read
        do_read(6'd5);
        chk("lit_rd_valid_1", 256'(bus.rd_valid), 256'd1);
        tick();
        bus.rd_en = 1'b1; bus.rd_set = 6'd5; resetn = 1'b0;
        tick();
        bus.rd_en = 1'b0; resetn = 1'b1;
        chk("lit_rst_rd_valid", 256'(bus.rd_valid), 256'd0);
        chk("lit_rst_rd_data",  256'(|bus.rd_data), 256'd0);

        // known contents in the other ways of set 9
        for (int w = 0; w < 4; w++) begin
            if (w != 2) begin
                refill(2'(w), 6'd9, 8, 8, 0, 0, 32'hA000_0000 + 32'(w << 16), 32'd1);
                repeat (2) tick();
            end
        end

        // full refill, way 2 set 9
        refill(2'd2, 6'd9, 8, 8, 0, 0, 32'h1111_1111, 32'h1111_1111);
        chk("lit_rf_done_pulse", 256'(bus.rf_done), 256'd1);
        tick();
        chk("lit_rf_done_low", 256'(bus.rf_done), 256'd0);
        do_read(6'd9);
        chk("lit_line_a", bus.rd_data[2*256 +: 256], LINE_A);
        chk("lit_way0_beat0", 256'(bus.rd_data[31:0]), 256'h A000_0000);

        // byte-masked store, and an all-zero strobe
        do_store(2'd2, 6'd9, 3'd3, 4'b0101, 32'hAABB_CCDD);
        do_store(2'd2, 6'd9, 3'd0, 4'b0000, 32'hFFFF_FFFF);
        do_read(6'd9);
        chk("lit_line_b", bus.rd_data[2*256 +: 256], LINE_B);

        // early beat_last
        refill(2'd1, 6'd4, 3, 3, 0, 0, 32'h0101_0101, 32'h0101_0101);
        repeat (2) tick();
        do_read(6'd4);
        chk("lit_early_last", bus.rd_data[1*256 +: 256],
            256'h00000000_00000000_00000000_00000000_00000000_03030303_02020202_01010101);

        // ten beats offered without beat_last
        refill(2'd0, 6'd7, 10, 0, 0, 0, 32'hC000_0000, 32'd1);
        chk("lit_beat_ready_off", 256'(bus.beat_ready), 256'd0);
        tick();
        do_read(6'd7);
        chk("lit_ten_beats", bus.rd_data[255:0],
            256'hC0000007_C0000006_C0000005_C0000004_C0000003_C0000002_C0000001_C0000000);

        // store offered during COMMIT
        refill(2'd3, 6'd4, 8, 8, 0, 0, 32'hD000_0000, 32'd1);
        bus.wr_en = 1'b1; bus.wr_way = 2'd2; bus.wr_set = 6'd9; bus.wr_off = 3'd3;
        bus.wr_strb = 4'hF; bus.wr_data = 32'h0;
        chk("lit_wr_ready_commit", 256'(bus.wr_ready), 256'd0);
        tick();
        bus.wr_en = 1'b0;
        do_read(6'd9);
        chk("lit_commit_store_blocked", bus.rd_data[2*256 +: 256], LINE_B);

        // rf_start during FILL is ignored
        refill(2'd3, 6'd5, 8, 8, 0, 4, 32'hE000_0000, 32'd1);
        repeat (2) tick();
        do_read(6'd5);
        chk("lit_glitch_line", 256'(bus.rd_data[3*256 +: 32]), 256'hE000_0000);

        // reset on the fifth beat: no commit, line unchanged
        refill(2'd2, 6'd9, 8, 8, 5, 0, 32'hF000_0000, 32'd1);
        repeat (2) tick();
        do_read(6'd9);
        chk("lit_rst_refill_line", bus.rd_data[2*256 +: 256], LINE_B);

        // same-cycle store and read of set 9
        bus.rd_en = 1'b1; bus.rd_set = 6'd9;
        do_store(2'd2, 6'd9, 3'd0, 4'hF, 32'h1234_5678);
        bus.rd_en = 1'b0;
`ifdef DBANK_BYPASS_EN
        chk("lit_same_cycle", 256'(bus.rd_data[2*256 +: 32]), 256'h1234_5678);
`else
        chk("lit_same_cycle", 256'(bus.rd_data[2*256 +: 32]), 256'h1111_1111);
`endif
        do_read(6'd9);
        chk("lit_next_read", 256'(bus.rd_data[2*256 +: 32]), 256'h1234_5678);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cache_data_bank.md
Name: cache_data_bank

Overview:
- Multi-way L1 cache data storage for the custom CPU's I/D caches; the parametrised successor to the single-way line array.
- Holds WAYS x SETS lines. All ways of a set are read together through a registered read port.
- Single store-hit path: one beat per cycle, byte-masked.
- Built-in refill sequencer: assembles a burst of memory beats into one line, then commits it to a chosen way.

Parameters:
- WAYS, 4, number of ways
- SET_AW, 6, set index width (SETS = 2**SET_AW)
- LINE_W, 256, line width in bits
- BEAT_W, 32, store/refill beat width in bits; LINE_W must be a multiple of BEAT_W
- WAY_AW, 2, way index width (>= clog2(WAYS))
- OFF_AW, 3, beat offset width (= clog2(LINE_W/BEAT_W))

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- rd_en  in  1  read request
- rd_set  in  SET_AW  read set index
- rd_valid  out  1  rd_data valid; asserted the cycle after an accepted rd_en
- rd_data  out  WAYS*LINE_W  all ways of the set; way w at [w*LINE_W +: LINE_W]
- wr_en  in  1  store-hit write
- wr_ready  out  1  store accepted this cycle
- wr_way  in  WAY_AW  target way
- wr_set  in  SET_AW  target set
- wr_off  in  OFF_AW  beat offset within line
- wr_strb  in  BEAT_W/8  byte enables
- wr_data  in  BEAT_W  store data
- rf_start  in  1  begin refill
- rf_way  in  WAY_AW  refill victim way
- rf_set  in  SET_AW  refill set
- beat_valid  in  1  refill beat valid
- beat_ready  out  1  refill beat accepted
- beat_data  in  BEAT_W  refill beat
- beat_last  in  1  final beat of burst
- rf_busy  out  1  refill in progress (FILL or COMMIT)
- rf_done  out  1  one-cycle pulse when the line is written

Behaviour:
- Reset (resetn=0 at posedge): rd_valid=0, rd_data=0, rf_busy=0, rf_done=0, beat_ready=0, FSM=IDLE, beat counter=0. Storage array is not cleared.
- Read:
  - Latency 1. rd_en sampled at posedge N gives rd_valid=1 and rd_data = {way3..way0} of rd_set after posedge N.
  - rd_data holds its value when rd_en=0; rd_valid falls to 0.
- Store:
  - wr_ready = 1 except in COMMIT.
  - On wr_en && wr_ready: only bytes with wr_strb[i]=1 of beat wr_off in line (wr_set, wr_way) are updated.
  - wr_strb=0 is a no-op.
- Refill FSM:
  - IDLE:
    - rf_start latches rf_way/rf_set, clears the line buffer to 0 and the counter to 0, then goes to FILL.
    - rf_busy=1 from the next cycle.
  - FILL:
    - beat_ready=1. Each beat_valid&&beat_ready writes beat_data into buffer slot [counter] and increments the counter.
    - Go to COMMIT when beat_last is accepted, or when the counter reaches LINE_W/BEAT_W-1 and a beat is accepted.
    - beat_last is ignored for counter purposes; an early beat_last leaves the remaining slots 0.
  - COMMIT:
    - beat_ready=0, wr_ready=0. The full buffer is written to (set, way).
    - rf_done=1 for this one cycle. Next state is IDLE.
  - rf_start outside IDLE is ignored.
- A store accepted during FILL to the refilling set/way is written to the array but is overwritten by COMMIT. Cache control must not issue it.
- Same-cycle read and write to the same set (store or COMMIT): see the optional feature.
- Reset mid-refill: FSM returns to IDLE, no commit, rf_done stays 0, array unchanged.
- Counter is OFF_AW bits wide and never wraps; the transition to COMMIT precedes any overflow.

Optional Feature:
- Macro: DBANK_BYPASS_EN.
- Defined: write-first forwarding. A read of a set written in the same cycle returns the post-write line for the written way, byte-merged for stores; other ways return stored data.
- Undefined: read-first. rd_data returns pre-write contents; the new data is visible from the next read.

Test Plan:
- Reset then rd_en set 5 -> rd_valid=1 next cycle; rd_data=0 after reset and before any write is not checked. resetn=0 mid-read -> rd_valid=0, rd_data=0.
- Refill way 2, set 9 with 8 beats 0x11111111..0x88888888, beat_last on beat 8 -> rf_done one cycle after the 8th beat accepted; read set 9 -> way 2 = 0x88888888_..._11111111, other ways unchanged.
- Store way 2, set 9, off 3, strb 4'b0101, data 0xAABBCCDD -> beat 3 becomes 0x44BB44DD.
- Refill with beat_last on beat 3 -> beats 3..7 = 0; 10 valid beats without beat_last -> only the first 8 accepted, beat_ready=0 after the 8th.
- Store asserted during COMMIT -> wr_ready=0 and array untouched; rf_start during FILL ignored; resetn=0 at beat 5 -> no rf_done, line unchanged.
- Store and read of set 9 in the same cycle -> with DBANK_BYPASS_EN new bytes returned; without it old bytes returned, new bytes seen on the next read.
